// File: rtl/regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// regfile_wb_sink
//
// Receiving end of the writeback stage: a 2**ADDR_WIDTH x DATA_WIDTH MIPS
// general-purpose register file with two combinational decode read ports
// and a per-register pending-write scoreboard.
//
// Register 0 is hardwired to zero: writes to it are dropped, reads return 0,
// and its busy bit is never set.
//
// Scoreboard: an execute-stage producer (IssueValidE/WriteRegE) marks its
// destination busy; the matching writeback (RegWriteW/WriteRegW) clears it.
// When set and clear hit the same index in one cycle, the set wins because
// the newer producer is still in flight. FlushAll clears every busy bit and
// overrides set/clear, but never blocks a writeback's data write.
//
// Optional build macro:
//   REGFILE_WRITE_BYPASS_EN - write-through bypass. A writeback to the index
//   being read is forwarded to RD1/RD2 in the same cycle, and the matching
//   Busy1/Busy2 reads 0 (first-half write / second-half read).
//   Undefined: reads show only stored state.
//
// Ports:
//   CLK        in   clock, all state on rising edge
//   RST        in   synchronous active-high reset (highest priority)
//   RegWriteW  in   writeback write enable
//   WriteRegW  in   writeback destination index
//   ResultW    in   writeback data
//   A1, A2     in   read port indices (rs, rt)
//   RD1, RD2   out  combinational read data
//   IssueValidE in  producer leaving execute, will write WriteRegE
//   WriteRegE  in   destination of that producer
//   FlushAll   in   clear all busy bits next edge
//   Busy1/2    out  combinational busy flag for A1/A2
//   BusyCount  out  registered count of busy registers
// ---------------------------------------------------------------------------
module regfile_wb_sink #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RegWriteW,
   input  logic [ADDR_WIDTH-1:0] WriteRegW,
   input  logic [DATA_WIDTH-1:0] ResultW,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2,
   input  logic                  IssueValidE,
   input  logic [ADDR_WIDTH-1:0] WriteRegE,
   input  logic                  FlushAll,
   output logic                  Busy1,
   output logic                  Busy2,
   output logic [ADDR_WIDTH:0]   BusyCount
);

   localparam int NREGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [NREGS-1:0]      busy_q, busy_d;
   logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

   logic wb_we;   // writeback that actually lands in storage
   logic iss_set; // issue that actually marks a register busy

   assign wb_we   = RegWriteW   && (WriteRegW != '0);
   assign iss_set = IssueValidE && (WriteRegE != '0);

   // ------------------------------------------------------------------
   // Register storage. Entry 0 is only ever loaded by reset; reads of
   // index 0 are forced to zero below regardless.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_we) begin
         regs_q[WriteRegW] <= ResultW;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard next state. Ordering of the statements encodes priority:
   // clear first, set overrides clear on the same index, flush overrides
   // both. Bit 0 is pinned low so BusyCount tops out at NREGS-1.
   // ------------------------------------------------------------------
   always_comb begin
      busy_d = busy_q;
      if (RegWriteW) begin
         busy_d[WriteRegW] = 1'b0;
      end
      if (iss_set) begin
         busy_d[WriteRegE] = 1'b1;
      end
      if (FlushAll) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // Count computed from next-state bits so it moves on the same edge.
   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_cnt_d = busy_cnt_d + (ADDR_WIDTH + 1)'(busy_d[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign BusyCount = busy_cnt_q;

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] rd1_stored, rd2_stored;

   assign rd1_stored = (A1 == '0) ? '0 : regs_q[A1];
   assign rd2_stored = (A2 == '0) ? '0 : regs_q[A2];

`ifdef REGFILE_WRITE_BYPASS_EN
   // Same-cycle forwarding of the writeback. wb_we already excludes
   // index 0, so a read of register 0 can never be bypassed.
   logic hit1, hit2;

   assign hit1  = wb_we && (WriteRegW == A1);
   assign hit2  = wb_we && (WriteRegW == A2);
   assign RD1   = hit1 ? ResultW : rd1_stored;
   assign RD2   = hit2 ? ResultW : rd2_stored;
   assign Busy1 = busy_q[A1] && !hit1;
   assign Busy2 = busy_q[A2] && !hit2;
`else
   assign RD1   = rd1_stored;
   assign RD2   = rd2_stored;
   assign Busy1 = busy_q[A1];
   assign Busy2 = busy_q[A2];
`endif

endmodule

// File: tb/tb_regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_sink
//
// Directed bench for regfile_wb_sink. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 more unit later, well away from the
// next edge. Expected values are hand-derived constants; the only build
// dependency is the same-cycle bypass behaviour.
// ---------------------------------------------------------------------------
module tb_regfile_wb_sink;

`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic [4:0]  A1, A2;
   logic [31:0] RD1, RD2;
   logic        IssueValidE;
   logic [4:0]  WriteRegE;
   logic        FlushAll;
   logic        Busy1, Busy2;
   logic [5:0]  BusyCount;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   regfile_wb_sink #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .CLK(CLK), .RST(RST),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .IssueValidE(IssueValidE), .WriteRegE(WriteRegE), .FlushAll(FlushAll),
      .Busy1(Busy1), .Busy2(Busy2), .BusyCount(BusyCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs may be changed right after return.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Drop all one-shot controls.
   task automatic idle();
      RegWriteW = 0; WriteRegW = 0; ResultW = 0;
      IssueValidE = 0; WriteRegE = 0; FlushAll = 0; RST = 0;
   endtask

   initial begin
      idle();
      A1 = 0; A2 = 0;

      // Reset for two cycles
      RST = 1;
      step(); step();
      RST = 0; A1 = 5; A2 = 31;
      #1;
      chk("rst_rd1",   RD1, 0);
      chk("rst_rd2",   RD2, 0);
      chk("rst_busy1", Busy1, 0);
      chk("rst_busy2", Busy2, 0);
      chk("rst_cnt",   BusyCount, 0);

      // Write 0xDEADBEEF to reg 8; same-cycle view depends on bypass
      RegWriteW = 1; WriteRegW = 8; ResultW = 32'hDEADBEEF; A1 = 8;
      #1;
      chk("wr8_same", RD1, BYP ? 32'hDEADBEEF : 32'h0);
      step(); idle();
      #1;
      chk("wr8_next", RD1, 32'hDEADBEEF);

      // Write reg 31, read through port 2
      RegWriteW = 1; WriteRegW = 31; ResultW = 32'h0BADF00D; A2 = 31;
      step(); idle();
      #1;
      chk("wr31_rd2", RD2, 32'h0BADF00D);
      chk("wr8_kept", RD1, 32'hDEADBEEF);

      // Register 0: write and issue both ignored
      RegWriteW = 1; WriteRegW = 0; ResultW = 32'hFFFFFFFF;
      IssueValidE = 1; WriteRegE = 0; A1 = 0;
      step(); idle();
      #1;
      chk("r0_rd1",   RD1, 0);
      chk("r0_busy1", Busy1, 0);
      chk("r0_cnt",   BusyCount, 0);

      // Scoreboard lifecycle on reg 9
      IssueValidE = 1; WriteRegE = 9; A1 = 9;
      step(); idle();
      #1;
      chk("sb9_set_busy", Busy1, 1);
      chk("sb9_set_cnt",  BusyCount, 1);
      RegWriteW = 1; WriteRegW = 9; ResultW = 32'h99;
      #1;
      chk("sb9_byp_busy", Busy1, BYP ? 1'b0 : 1'b1);
      chk("sb9_byp_rd1",  RD1, BYP ? 32'h99 : 32'h0);
      step(); idle();
      #1;
      chk("sb9_clr_busy", Busy1, 0);
      chk("sb9_clr_cnt",  BusyCount, 0);
      chk("sb9_data",     RD1, 32'h99);

      // Simultaneous set and clear on reg 9: set wins
      IssueValidE = 1; WriteRegE = 9;
      step(); idle();
      IssueValidE = 1; WriteRegE = 9; RegWriteW = 1; WriteRegW = 9; ResultW = 32'h9A;
      step(); idle();
      #1;
      chk("same_busy", Busy1, 1);
      chk("same_cnt",  BusyCount, 1);

      // Re-set an already busy bit: no double count
      IssueValidE = 1; WriteRegE = 9;
      step(); idle();
      #1;
      chk("reset_busy_cnt", BusyCount, 1);

      // Clear a non-busy register (20): no effect on count
      RegWriteW = 1; WriteRegW = 20; ResultW = 32'h20;
      step(); idle();
      #1;
      chk("clr_idle_cnt", BusyCount, 1);

      // Different indices same cycle: set 10, clear 9
      IssueValidE = 1; WriteRegE = 10; RegWriteW = 1; WriteRegW = 9; ResultW = 32'h9B;
      A1 = 9; A2 = 10;
      step(); idle();
      #1;
      chk("diff_busy9",  Busy1, 0);
      chk("diff_busy10", Busy2, 1);
      chk("diff_cnt",    BusyCount, 1);

      // Retire 10, then make 3, 4, 7 busy
      RegWriteW = 1; WriteRegW = 10; ResultW = 32'h10;
      step(); idle();
      IssueValidE = 1; WriteRegE = 3; step();
      WriteRegE = 4; step();
      WriteRegE = 7; step();
      idle();
      #1;
      chk("three_cnt", BusyCount, 3);

      // Flush overrides a new issue; same-cycle writeback still writes data
      FlushAll = 1; IssueValidE = 1; WriteRegE = 12;
      RegWriteW = 1; WriteRegW = 3; ResultW = 32'h33;
      step(); idle();
      A1 = 12; A2 = 3;
      #1;
      chk("flush_cnt",    BusyCount, 0);
      chk("flush_busy12", Busy1, 0);
      chk("flush_busy3",  Busy2, 0);
      chk("flush_data3",  RD2, 32'h33);

      // Reset beats a simultaneous write and issue
      IssueValidE = 1; WriteRegE = 5;
      step(); idle();
      RST = 1; RegWriteW = 1; WriteRegW = 4; ResultW = 32'h1234;
      IssueValidE = 1; WriteRegE = 6;
      step(); idle();
      A1 = 4; A2 = 8;
      #1;
      chk("rstpri_rd4", RD1, 0);
      chk("rstpri_rd8", RD2, 0);
      chk("rstpri_cnt", BusyCount, 0);
      A1 = 6;
      #1;
      chk("rstpri_busy6", Busy1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
